// File: rtl/store_lane_sequencer.sv
// Store lane sequencer: places right-aligned store data into byte lanes of a
// DATA_W memory port, splitting lane-crossing stores into two beats.
// Ports: clk/reset; req_* (valid/ready store request: addr, size, wdata);
// mem_* (valid/ready beat: addr, wdata, be); err (reject pulse).
module store_lane_sequencer #(
  parameter int DATA_W           = 32,
  parameter int ALLOW_MISALIGNED = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [31:0]         req_addr,
  input  logic [1:0]          req_size,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic [31:0]         mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  output logic                err
);

  localparam int NB   = DATA_W / 8;
  localparam int OFFW = $clog2(NB);

  typedef enum logic [1:0] {
    IDLE, BEAT0, BEAT1, ERR
  } state_t;

  state_t state_q, state_d;

  logic [31:0]       addr_q;
  logic [1:0]        size_q;
  logic [DATA_W-1:0] wdata_q;

  function automatic logic [4:0] len_of(
    input logic [1:0] s
  );
    unique case (s)
      2'b00:   len_of = 5'd1;
      2'b01:   len_of = 5'd2;
      2'b10:   len_of = 5'd4;
      default: len_of = 5'd8;
    endcase
  endfunction

  // Legality is judged on the live inputs so the
  // IDLE decision needs no extra cycle.
  logic [OFFW-1:0] in_off;
  logic            in_cross;
  logic            in_illegal;
  logic            accept;

  assign in_off   = req_addr[OFFW-1:0];
  assign in_cross = (5'(in_off) + len_of(req_size))
                    > 5'(NB);
  assign in_illegal =
    (in_cross && (ALLOW_MISALIGNED == 0)) ||
    ((req_size == 2'b11) && (DATA_W == 32));
  assign accept = (state_q == IDLE) && req_valid;

  logic [OFFW-1:0]   off;
  logic              cross_q;
  logic [2*NB-1:0]   lmask;
  logic [2*NB-1:0]   mask;
  logic [OFFW+2:0]   sh0;
  logic [OFFW+3:0]   sh1;
  logic [31:0]       base;

  assign off     = addr_q[OFFW-1:0];
  assign cross_q = (5'(off) + len_of(size_q)) > 5'(NB);

  always_comb begin
    lmask = '0;
    unique case (size_q)
      2'b00:   lmask = (2*NB)'(16'h0001);
      2'b01:   lmask = (2*NB)'(16'h0003);
      2'b10:   lmask = (2*NB)'(16'h000F);
      default: lmask = (2*NB)'(16'h00FF);
    endcase
  end

  // Mask spans two beats; low half is BEAT0.
  assign mask = lmask << off;
  assign sh0  = {off, 3'b000};
  assign sh1  = (OFFW+4)'(NB*8) - {1'b0, off, 3'b000};
  assign base = {addr_q[31:OFFW], {OFFW{1'b0}}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      addr_q  <= req_addr;
      size_q  <= req_size;
      wdata_q <= req_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (req_valid)
          state_d = in_illegal ? ERR : BEAT0;
      BEAT0:
        if (mem_ready)
          state_d = cross_q ? BEAT1 : IDLE;
      BEAT1:
        if (mem_ready) state_d = IDLE;
      ERR:
        state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    err       = 1'b0;
    unique case (state_q)
      BEAT0: begin
        mem_valid = 1'b1;
        mem_addr  = base;
        mem_be    = mask[NB-1:0];
        mem_wdata = wdata_q << sh0;
      end
      BEAT1: begin
        mem_valid = 1'b1;
        mem_addr  = base + 32'(NB);
        mem_be    = mask[2*NB-1:NB];
        mem_wdata = wdata_q >> sh1;
      end
      ERR:
        err = 1'b1;
      default: ;
    endcase
  end

  // Held low while reset is asserted, even though
  // the FSM already sits in IDLE.
  assign req_ready = (state_q == IDLE) && !reset;

endmodule

// File: doc/store_lane_sequencer.md
STORE_LANE_SEQUENCER -- requirements
Module: store_lane_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, memory data width in bits; legal values 32, 64; NB = DATA_W/8.
REQ-002 SHALL have parameter ALLOW_MISALIGNED, default 1; 1 = split lane-crossing stores, 0 = reject them.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  store request valid.
REQ-006 SHALL have port req_ready  output  1  request accepted when req_valid && req_ready.
REQ-007 SHALL have port req_addr  input  32  byte address.
REQ-008 SHALL have port req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = dword (DATA_W = 64 only).
REQ-009 SHALL have port req_wdata  input  DATA_W  store data, right-aligned.
REQ-010 SHALL have port mem_valid  output  1  memory beat valid.
REQ-011 SHALL have port mem_ready  input  1  memory accepts beat when mem_valid && mem_ready.
REQ-012 SHALL have port mem_addr  output  32  NB-aligned beat address.
REQ-013 SHALL have port mem_wdata  output  DATA_W  lane-positioned data.
REQ-014 SHALL have port mem_be  output  NB  byte enables.
REQ-015 SHALL have port err  output  1  one-cycle pulse for a rejected request.

Function
REQ-016 SHALL implement FSM states IDLE, BEAT0, BEAT1, ERR; req_ready = 1 only in IDLE.
REQ-017 SHALL register addr, size and wdata on acceptance; the first mem_valid occurs in the cycle after acceptance.
REQ-018 SHALL compute off = addr mod NB, len = 2^size bytes, and mask = ((1<<len)-1) << off over 2*NB bits.
REQ-019 SHALL flag a request as crossing when off + len > NB.
REQ-020 SHALL flag a request as illegal when it is crossing with ALLOW_MISALIGNED = 0, or when size = 11 with DATA_W = 32.
REQ-021 SHALL move IDLE -> ERR on acceptance of an illegal request; ERR asserts err for exactly one cycle, issues no beat, and returns to IDLE.
REQ-022 SHALL move IDLE -> BEAT0 on acceptance of a legal request.
REQ-023 SHALL drive the following in BEAT0: mem_addr = addr & ~(NB-1); mem_be = mask[NB-1:0]; mem_wdata = wdata << (8*off), truncated to DATA_W.
REQ-024 SHALL drive the following in BEAT1: mem_addr = (BEAT0 address + NB) mod 2^32; mem_be = mask[2NB-1:NB]; mem_wdata = wdata >> (8*(NB-off)).
REQ-025 SHALL, on a BEAT0 handshake, go to BEAT1 if the request is crossing, else to IDLE; on a BEAT1 handshake, go to IDLE.
REQ-026 SHALL hold mem_valid high and mem_addr, mem_wdata and mem_be stable until the handshake while mem_ready = 0.
REQ-027 SHALL drive mem_valid = 0, mem_be = 0 and mem_wdata = 0 in IDLE and ERR.
REQ-028 SHALL ignore req_* inputs while not in IDLE; no request is queued.
REQ-029 SHALL allow at most one request in flight; the minimum store throughput is 2 cycles per aligned store and 3 cycles per split store.
REQ-030 SHALL wrap the BEAT1 address modulo 2^32, so that 0xFFFFFFFC + 4 gives 0x00000000.

Reset
REQ-031 SHALL, while reset = 1, immediately force the FSM to IDLE, mem_valid = 0, mem_be = 0, mem_addr = 0, mem_wdata = 0, err = 0 and req_ready = 0.
REQ-032 SHALL set req_ready = 1 in the first cycle after reset deasserts.
REQ-033 SHALL discard any request in flight at reset, including the pending second beat of a split store; no further beat is issued.

Verification (DATA_W = 32)
REQ-034 SHALL cover: word store, addr 0x100, data 0xDEADBEEF -> one beat: mem_addr 0x100, be 1111, wdata 0xDEADBEEF; IDLE 2 cycles after acceptance.
REQ-035 SHALL cover: byte store, addr 0x103, data 0x000000AB -> mem_addr 0x100, be 1000, wdata 0xAB000000.
REQ-036 SHALL cover: half store, addr 0x103, data 0x1234, ALLOW_MISALIGNED = 1 -> beat 1: 0x100, be 1000, 0x34000000; then beat 2: 0x104, be 0001, 0x00000012.
REQ-037 SHALL cover: the REQ-036 stimulus with ALLOW_MISALIGNED = 0 -> err high for 1 cycle, mem_valid never asserted; also size 11 -> err.
REQ-038 SHALL cover: mem_ready held low 3 cycles during BEAT0 -> mem_* stable across all cycles; a single handshake follows.
REQ-039 SHALL cover: word store at 0xFFFFFFFE, then reset asserted in BEAT1 -> beat 1 at 0xFFFFFFFC, be 1100; beat 2 at 0x00000000, be 0011; mem_valid drops asynchronously on reset, and req_ready = 1 the cycle after release.
